// File: rtl/div_unit_pkg.sv
// Shared constants and state encoding for the multi-cycle integer divider.
package div_unit_pkg;

    localparam int unsigned DIV_WIDTH = 32;
    localparam int unsigned DIV_CNT_W = 6;

    typedef enum logic [1:0] {
        DIV_FREE    = 2'b00,
        DIV_BY_ZERO = 2'b01,
        DIV_ON      = 2'b10,
        DIV_END     = 2'b11
    } div_state_e;

    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;
    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring iteration: shift in a dividend bit, trial-subtract the divisor.
module div_step
    import div_unit_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             qbit_o
);

    logic [WIDTH:0] shifted_c;

    // The shifted remainder needs one extra bit; the restored result always fits WIDTH.
    assign shifted_c = {rem_i, bit_i};
    assign qbit_o    = (shifted_c >= {1'b0, divisor_i});
    assign rem_o     = qbit_o ? WIDTH'(shifted_c - {1'b0, divisor_i}) : WIDTH'(shifted_c);

endmodule

// File: rtl/div_unit.sv
// Multi-cycle DIV/DIVU unit returning {remainder, quotient}.
// Optional early-out for |dividend| < |divisor| is enabled by DIV_EARLY_OUT_EN.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH,
    parameter int unsigned CNT_W = DIV_CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o
);

    div_state_e           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]     dvd_q, dvd_d;
    logic [WIDTH-1:0]     dvs_q, dvs_d;
    logic [WIDTH-1:0]     rem_q, rem_d;
    logic [WIDTH-1:0]     quot_q, quot_d;
    logic                 neg_quot_q, neg_quot_d;
    logic                 neg_rem_q, neg_rem_d;
    logic [2*WIDTH-1:0]   result_q, result_d;
    logic                 ready_q, ready_d;

    logic [WIDTH-1:0]     mag1_c, mag2_c;
    logic [WIDTH-1:0]     step_rem_c, quot_fin_c, quot_out_c, rem_out_c;
    logic                 step_qbit_c;

    // Operand magnitudes; signed negatives are two's-complement negated.
    assign mag1_c = (signed_div_i && opdata1_i[WIDTH-1]) ? (~opdata1_i + WIDTH'(1)) : opdata1_i;
    assign mag2_c = (signed_div_i && opdata2_i[WIDTH-1]) ? (~opdata2_i + WIDTH'(1)) : opdata2_i;

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_i     (rem_q),
        .bit_i     (dvd_q[WIDTH-1]),
        .divisor_i (dvs_q),
        .rem_o     (step_rem_c),
        .qbit_o    (step_qbit_c)
    );

    // Final iteration result with the sign correction folded in.
    assign quot_fin_c = WIDTH'({quot_q, step_qbit_c});
    assign quot_out_c = neg_quot_q ? (~quot_fin_c + WIDTH'(1)) : quot_fin_c;
    assign rem_out_c  = neg_rem_q  ? (~step_rem_c + WIDTH'(1)) : step_rem_c;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= DIV_FREE;
            cnt_q      <= '0;
            dvd_q      <= '0;
            dvs_q      <= '0;
            rem_q      <= '0;
            quot_q     <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            result_q   <= '0;
            ready_q    <= DIV_RESULT_NOT_READY;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dvd_q      <= dvd_d;
            dvs_q      <= dvs_d;
            rem_q      <= rem_d;
            quot_q     <= quot_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
            result_q   <= result_d;
            ready_q    <= ready_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dvd_d      = dvd_q;
        dvs_d      = dvs_q;
        rem_d      = rem_q;
        quot_d     = quot_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        result_d   = result_q;
        ready_d    = ready_q;

        unique case (state_q)
            DIV_FREE: begin
                result_d = '0;
                ready_d  = DIV_RESULT_NOT_READY;
                if (start_i == DIV_START && !annul_i) begin
                    neg_quot_d = signed_div_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                    neg_rem_d  = signed_div_i & opdata1_i[WIDTH-1];
                    dvd_d      = mag1_c;
                    dvs_d      = mag2_c;
                    rem_d      = '0;
                    quot_d     = '0;
                    cnt_d      = '0;
                    if (opdata2_i == '0) begin
                        state_d = DIV_BY_ZERO;
`ifdef DIV_EARLY_OUT_EN
                    end else if (mag1_c < mag2_c) begin
                        // Shares the one-cycle hold state; remainder is the untouched dividend.
                        rem_d   = opdata1_i;
                        state_d = DIV_BY_ZERO;
`endif
                    end else begin
                        state_d = DIV_ON;
                    end
                end
            end
            DIV_BY_ZERO: begin
                if (annul_i) begin
                    state_d = DIV_FREE;
                end else begin
                    state_d  = DIV_END;
                    result_d = {rem_q, quot_q};
                    ready_d  = DIV_RESULT_READY;
                end
            end
            DIV_ON: begin
                if (annul_i) begin
                    state_d = DIV_FREE;
                end else begin
                    dvd_d  = {dvd_q[WIDTH-2:0], 1'b0};
                    rem_d  = step_rem_c;
                    quot_d = quot_fin_c;
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_d  = DIV_END;
                        result_d = {rem_out_c, quot_out_c};
                        ready_d  = DIV_RESULT_READY;
                    end
                end
            end
            DIV_END: begin
                if (start_i == DIV_STOP) begin
                    state_d  = DIV_FREE;
                    result_d = '0;
                    ready_d  = DIV_RESULT_NOT_READY;
                end
            end
            default: state_d = DIV_FREE;
        endcase
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle 32-bit integer divider serving the DIV/DIVU operations issued by the decode stage.
- Acts as the responder to the execute stage: execute raises start_i with operands and holds it until ready_o; execute stalls the pipeline meanwhile.
- Result returns as {remainder, quotient} for writing into HI/LO.
- Radix-2 restoring algorithm, one quotient bit per cycle.

Parameters:
- WIDTH, 32, operand width; quotient and remainder are each WIDTH bits.
- CNT_W, 6, width of the iteration counter; must hold WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-low (0 = reset).
- signed_div_i  input  1  1 = DIV (signed), 0 = DIVU; sampled at start acceptance.
- opdata1_i  input  WIDTH  dividend; sampled at start acceptance.
- opdata2_i  input  WIDTH  divisor; sampled at start acceptance.
- start_i  input  1  request; held high by execute until it sees ready_o.
- annul_i  input  1  abort an in-flight division (branch flush or exception).
- result_o  output  2*WIDTH  {remainder[2W-1:W], quotient[W-1:0]}.
- ready_o  output  1  result valid.

Behaviour:
- Reset (rst=0, any time, including mid-operation): state=DIV_FREE, counter=0, result_o=0, ready_o=0. Internal operand registers are cleared.
- States: DIV_FREE, DIV_BY_ZERO, DIV_ON, DIV_END.
- DIV_FREE, with start_i=1 and annul_i=0:
  - If opdata2_i==0, go to DIV_BY_ZERO.
  - Otherwise latch operands and go to DIV_ON with counter=0.
  - If signed_div_i=1, latch |opdata1_i| and |opdata2_i| (two's-complement negate when the MSB is set), and latch both sign bits.
  - If start_i=0 or annul_i=1, stay in DIV_FREE. ready_o=0, result_o=0.
- DIV_BY_ZERO: one cycle, then DIV_END with result 0 (quotient=0, remainder=0).
- DIV_ON, per cycle:
  - Shift the partial remainder left by 1 and append the next dividend bit, MSB first.
  - If the partial remainder >= divisor, subtract the divisor and set quotient bit 1; otherwise set quotient bit 0.
  - counter increments each cycle. After WIDTH iterations (counter==WIDTH-1 in the current cycle), go to DIV_END.
- Sign fix, applied on entry to DIV_END:
  - Quotient is negated if the dividend and divisor signs differ.
  - Remainder is negated if the dividend was negative.
  - Applies only when signed_div_i was 1 at acceptance.
- Annul:
  - annul_i=1 in DIV_ON or DIV_BY_ZERO forces DIV_FREE next cycle. No ready_o pulse; result_o=0.
  - annul_i in DIV_END is ignored.
- DIV_END:
  - ready_o=1 and result_o holds the result.
  - Stay while start_i=1. On start_i=0, go to DIV_FREE next cycle with ready_o=0 and result_o=0.
- Latency from accepted start to ready_o=1: WIDTH+1 cycles for WIDTH=32, i.e. 33 (1 DIV_FREE→DIV_ON edge plus 32 iterations). Divide-by-zero latency is 2 cycles.
- Overflow, signed 0x80000000 / 0xFFFFFFFF: quotient=0x80000000, remainder=0 (modular wrap; no trap).
- Inputs other than start_i/annul_i are ignored outside DIV_FREE. Operand changes mid-operation have no effect.
- Back-to-back: a new start is accepted only after returning to DIV_FREE, so at least one idle cycle separates operations.

Optional Feature:
- Macro DIV_EARLY_OUT_EN.
- Defined:
  - In DIV_FREE, if |dividend| < |divisor| (unsigned compare of the magnitudes), go directly to DIV_END.
  - Result there is quotient=0 and remainder=original opdata1_i, with sign preserved. Latency 2 cycles.
  - Divide-by-zero is checked first.
- Undefined: no comparator is built; all nonzero-divisor operations take the full WIDTH+1 cycles.

Decomposition:
- Shared defines file (existing defines.v):
  - state encodings DivFree/DivByZero/DivOn/DivEnd (2 bits);
  - DivResultReady/DivResultNotReady;
  - DivStart/DivStop;
  - DoubleRegBus (63:0).
- One natural sub-module: div_step, a combinational single iteration (partial remainder in, divisor in → next remainder, quotient bit). div_unit holds the registers, counter and FSM.

Test Plan:
- DIVU 100/7, start held → ready_o=1 exactly 33 cycles after acceptance; result_o={32'd2, 32'd14}; ready_o drops the cycle after start_i=0.
- DIV 0xFFFFFF9C(-100)/7 → quotient 0xFFFFFFF2 (-14), remainder 0xFFFFFFFE (-2); also 100/-7 → quotient -14, remainder 2.
- DIV 0x80000000/0xFFFFFFFF → quotient 0x80000000, remainder 0; DIVU 5/0 → ready_o after 2 cycles, result_o=0.
- annul_i=1 at iteration 10 of DIVU 0xFFFFFFFF/3 → next cycle state DIV_FREE, ready_o never asserts; a following DIVU 9/3 gives {0,3}.
- rst=0 asynchronously at iteration 20 → result_o=0 and ready_o=0 immediately without a clock edge; after release, DIVU 12/4 → {0,3} in 33 cycles.
- With DIV_EARLY_OUT_EN: DIV -3/10 → ready_o after 2 cycles, result_o={0xFFFFFFFD, 0}; without it the same operation takes 33 cycles with the same result.
